// File: rtl/hc128_stream_core.sv
// rtl/hc128_stream_core.sv - HC-128 keystream generator with output FIFO
//
// Ports:
//   clk             in   1    rising-edge clock
//   reset           in   1    asynchronous active-high reset
//   init            in   1    pulse: capture key/iv and (re)start initialisation
//   key             in   128  K[i] = key[32i+31:32i]
//   iv              in   128  IV[i] = iv[32i+31:32i]
//   ready           out  1    initialisation complete, keystream running
//   keystream_data  out  32   FIFO head word, 0 when empty
//   keystream_valid out  1    FIFO non-empty
//   keystream_ack   in   1    consumer takes the head word when valid
module hc128_stream_core #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    output logic         ready,
    output logic [31:0]  keystream_data,
    output logic         keystream_valid,
    input  logic         keystream_ack
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_MIX,
        S_RUN
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] f1(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f2(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] g1(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (rotr(x, 10) ^ rotr(z, 23)) + rotr(y, 8);
    endfunction

    function automatic logic [31:0] g2(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (rotl(x, 10) ^ rotl(z, 23)) + rotl(y, 8);
    endfunction

    state_t        state_q, state_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [31:0]   w_q [16];
    logic [31:0]   p_q [512];
    logic [31:0]   q_q [512];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic load_en, exp_en, mix_en, run_en, step_en, flush, push, pop, fifo_full;

    // Step datapath: j walks P while cnt[9]=0, Q while cnt[9]=1.
    logic [8:0]  j, j_m3, j_m10, j_p1, j_m12, exp_idx;
    logic [31:0] t_j, t_m3, t_m10, t_m511, t_new, h_val, s_word, tbl_wr, w_new;
    logic [7:0]  hb_lo, hb_hi;

    assign j     = cnt_q[8:0];
    assign j_m3  = j - 9'd3;
    assign j_m10 = j - 9'd10;
    assign j_p1  = j + 9'd1;      // j-511 mod 512
    assign j_m12 = j - 9'd12;

    // Expansion word i lands at P[i-256] or Q[i-768]; both equal (i-256) mod 512.
    assign exp_idx = {~cnt_q[8], cnt_q[7:0]};

    assign w_new = f2(w_q[14]) + w_q[9] + f1(w_q[1]) + w_q[0] + {21'd0, cnt_q};

    always_comb begin
        if (cnt_q[9]) begin
            t_j    = q_q[j];
            t_m3   = q_q[j_m3];
            t_m10  = q_q[j_m10];
            t_m511 = q_q[j_p1];
            t_new  = t_j + g2(t_m3, t_m10, t_m511);
            hb_lo  = q_q[j_m12][7:0];
            hb_hi  = q_q[j_m12][23:16];
            h_val  = p_q[{1'b0, hb_lo}] + p_q[{1'b1, hb_hi}];
        end else begin
            t_j    = p_q[j];
            t_m3   = p_q[j_m3];
            t_m10  = p_q[j_m10];
            t_m511 = p_q[j_p1];
            t_new  = t_j + g1(t_m3, t_m10, t_m511);
            hb_lo  = p_q[j_m12][7:0];
            hb_hi  = p_q[j_m12][23:16];
            h_val  = q_q[{1'b0, hb_lo}] + q_q[{1'b1, hb_hi}];
        end
    end

    assign s_word = h_val ^ t_new;
    // During MIX the output word is folded back into the table instead of emitted.
    assign tbl_wr = mix_en ? s_word : t_new;

    assign fifo_full = (count_q == DEPTH_C);

    // init overrides every state, including a pop presented in the same cycle.
    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        exp_en  = 1'b0;
        mix_en  = 1'b0;
        run_en  = 1'b0;
        flush   = 1'b0;
        pop     = 1'b0;
        if (init) begin
            state_d = S_LOAD;
            load_en = 1'b1;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: state_d = S_EXPAND;
                S_EXPAND: begin
                    exp_en = 1'b1;
                    if (cnt_q == 11'd1279) state_d = S_MIX;
                end
                S_MIX: begin
                    mix_en = 1'b1;
                    if (cnt_q[9:0] == 10'd1023) state_d = S_RUN;
                end
                S_RUN: begin
                    pop    = keystream_valid & keystream_ack;
                    run_en = ~fifo_full | pop;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign step_en = mix_en | run_en;
    assign push    = run_en;

    always_comb begin
        cnt_d = cnt_q;
        if (load_en) begin
            cnt_d = 11'd16;
        end else if (exp_en) begin
            cnt_d = (cnt_q == 11'd1279) ? 11'd0 : cnt_q + 11'd1;
        end else if (step_en) begin
            cnt_d = {1'b0, cnt_q[9:0] + 10'd1};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Window, tables and FIFO storage carry no reset; only their control does.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < 4; k++) begin
                w_q[k]      <= key[32*k +: 32];
                w_q[k + 4]  <= key[32*k +: 32];
                w_q[k + 8]  <= iv[32*k +: 32];
                w_q[k + 12] <= iv[32*k +: 32];
            end
        end else if (exp_en) begin
            for (int k = 0; k < 15; k++) begin
                w_q[k] <= w_q[k + 1];
            end
            w_q[15] <= w_new;
            if (cnt_q >= 11'd256 && cnt_q < 11'd768) begin
                p_q[exp_idx] <= w_new;
            end else if (cnt_q >= 11'd768) begin
                q_q[exp_idx] <= w_new;
            end
        end else if (step_en) begin
            if (cnt_q[9]) begin
                q_q[j] <= tbl_wr;
            end else begin
                p_q[j] <= tbl_wr;
            end
        end
        if (push) begin
            fifo_mem[wr_ptr_q] <= s_word;
        end
    end

    assign ready           = (state_q == S_RUN);
    assign keystream_valid = (count_q != '0);
    assign keystream_data  = keystream_valid ? fifo_mem[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_hc128_stream_core.sv
// tb/tb_hc128_stream_core.sv - self-checking bench for hc128_stream_core
module tb_hc128_stream_core;
    localparam int DEPTH = 4;
    localparam int LAT   = 2289;

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [127:0] key;
    logic [127:0] iv;
    logic         ready;
    logic [31:0]  keystream_data;
    logic         keystream_valid;
    logic         keystream_ack;

    hc128_stream_core #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .key             (key),
        .iv              (iv),
        .ready           (ready),
        .keystream_data  (keystream_data),
        .keystream_valid (keystream_valid),
        .keystream_ack   (keystream_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain HC-128 in software form) ----------------
    logic [31:0] mP [512];
    logic [31:0] mQ [512];
    int          mi;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction
    function automatic logic [31:0] mf1(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] mf2(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model_step(input bit mix, output logic [31:0] s);
        int j;
        logic [31:0] x, h;
        j = mi % 512;
        if (mi < 512) begin
            mP[j] = mP[j] + ((rr(mP[(j + 509) % 512], 10) ^ rr(mP[(j + 1) % 512], 23))
                             + rr(mP[(j + 502) % 512], 8));
            x = mP[(j + 500) % 512];
            h = mQ[x[7:0]] + mQ[256 + int'(x[23:16])];
            s = h ^ mP[j];
            if (mix) mP[j] = s;
        end else begin
            mQ[j] = mQ[j] + ((rl(mQ[(j + 509) % 512], 10) ^ rl(mQ[(j + 1) % 512], 23))
                             + rl(mQ[(j + 502) % 512], 8));
            x = mQ[(j + 500) % 512];
            h = mP[x[7:0]] + mP[256 + int'(x[23:16])];
            s = h ^ mQ[j];
            if (mix) mQ[j] = s;
        end
        mi = (mi + 1) % 1024;
    endtask

    task automatic model_init(input logic [127:0] k, input logic [127:0] v);
        logic [31:0] w [1280];
        logic [31:0] s;
        for (int i = 0; i < 4; i++) begin
            w[i]      = k[32*i +: 32];
            w[i + 4]  = k[32*i +: 32];
            w[i + 8]  = v[32*i +: 32];
            w[i + 12] = v[32*i +: 32];
        end
        for (int i = 16; i < 1280; i++) begin
            w[i] = mf2(w[i - 2]) + w[i - 7] + mf1(w[i - 15]) + w[i - 16] + 32'(i);
        end
        for (int i = 0; i < 512; i++) begin
            mP[i] = w[i + 256];
            mQ[i] = w[i + 768];
        end
        mi = 0;
        for (int i = 0; i < 1024; i++) model_step(1'b1, s);
    endtask

    task automatic model_fill(input int n);
        logic [31:0] s;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            model_step(1'b0, s);
            exp_q.push_back(s);
        end
    endtask

    // ---------------- DUT drivers (all start and end at posedge + 1) ----------------
    task automatic do_init(input logic [127:0] k, input logic [127:0] v);
        key           = k;
        iv            = v;
        init          = 1'b1;
        keystream_ack = 1'b0;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    // Random ack pulses while initialising must not produce any valid word.
    task automatic wait_ready(input string tag);
        int lat;
        bit bad_valid;
        lat       = 0;
        bad_valid = 1'b0;
        while (!ready && lat < 3000) begin
            keystream_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (keystream_valid) bad_valid = 1'b1;
        end
        keystream_ack = 1'b0;
        check32({tag, "_latency"}, 32'(lat), 32'(LAT));
        check32({tag, "_valid_during_init"}, 32'(bad_valid), 32'd0);
    endtask

    task automatic consume(input int n, input bit gaps, input string tag, output int cycles);
        int          got;
        bit          held_v;
        logic [31:0] held_d;
        logic [31:0] exp;
        got    = 0;
        cycles = 0;
        held_v = 1'b0;
        held_d = '0;
        while (got < n && cycles < 40 * n + 100) begin
            keystream_ack = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (held_v && keystream_valid) check32({tag, "_hold"}, keystream_data, held_d);
            held_v = 1'b0;
            if (keystream_valid) begin
                if (keystream_ack) begin
                    exp = exp_q.pop_front();
                    check32($sformatf("%s_word%0d", tag, got), keystream_data, exp);
                    got++;
                end else begin
                    held_v = 1'b1;
                    held_d = keystream_data;
                end
            end
            @(posedge clk); #1;
            cycles++;
        end
        keystream_ack = 1'b0;
        if (got < n) check32({tag, "_timeout"}, 32'(got), 32'(n));
    endtask

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] exp_w;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [127:0] ka, kb, ivb;
        logic [31:0]  s;
        int           cyc;
        bit           ready_seen;

        reset = 1'b1;
        init = 1'b0;
        key = '0;
        iv = '0;
        keystream_ack = 1'b0;

        vecs[0].key   = '0;
        vecs[0].iv    = '0;
        vecs[0].exp_w = {32'hAA63AF0E, 32'hFB2FD77F, 32'h3BFD03A0, 32'h73150082};
        for (int r = 1; r < 3; r++) begin
            vecs[r].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[r].iv  = (r == 2) ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
            model_init(vecs[r].key, vecs[r].iv);
            for (int w = 0; w < 4; w++) begin
                model_step(1'b0, s);
                vecs[r].exp_w[32*w +: 32] = s;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check32("rst_ready", 32'(ready), 32'd0);
        check32("rst_valid", 32'(keystream_valid), 32'd0);
        check32("rst_data", keystream_data, 32'd0);
        reset = 1'b0;

        // ack in IDLE does nothing
        keystream_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check32("idle_ack_valid", 32'(keystream_valid), 32'd0);
        check32("idle_ack_ready", 32'(ready), 32'd0);
        keystream_ack = 1'b0;

        // table-driven vectors
        for (int r = 0; r < 3; r++) begin
            do_init(vecs[r].key, vecs[r].iv);
            wait_ready($sformatf("vec%0d", r));
            exp_q.delete();
            for (int w = 0; w < 4; w++) exp_q.push_back(vecs[r].exp_w[32*w +: 32]);
            consume(4, 1'b0, $sformatf("vec%0d", r), cyc);
        end

        // back-pressure: fill FIFO, stall, then drain with random gaps
        model_init('0, '0);
        model_fill(64);
        do_init('0, '0);
        wait_ready("stall");
        repeat (30) @(posedge clk);
        #1;
        check32("stall_valid", 32'(keystream_valid), 32'd1);
        check32("stall_head", keystream_data, exp_q[0]);
        consume(64, 1'b1, "stall", cyc);

        // long random run across the P/Q switch and counter wraps
        ka = {$urandom, $urandom, $urandom, $urandom};
        ivb = {$urandom, $urandom, $urandom, $urandom};
        model_init(ka, ivb);
        model_fill(2100);
        do_init(ka, ivb);
        wait_ready("long");
        consume(2100, 1'b0, "long", cyc);
        check32("long_throughput_cycles", 32'(cyc), 32'd2101);

        // re-init mid-MIX with a different key
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        ivb = {$urandom, $urandom, $urandom, $urandom};
        model_init(kb, ivb);
        model_fill(8);
        do_init(ka, '0);
        ready_seen = 1'b0;
        repeat (1499) begin
            @(posedge clk); #1;
            if (ready) ready_seen = 1'b1;
        end
        check32("reinit_ready_before", 32'(ready_seen), 32'd0);
        do_init(kb, ivb);
        wait_ready("reinit");
        consume(8, 1'b0, "reinit", cyc);

        // async reset with FIFO part full, then full re-initialisation
        do_init('0, '0);
        wait_ready("arst_pre");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("arst_prefill_valid", 32'(keystream_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check32("arst_valid", 32'(keystream_valid), 32'd0);
        check32("arst_ready", 32'(ready), 32'd0);
        check32("arst_data", keystream_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_init('0, '0);
        wait_ready("arst_post");
        exp_q.delete();
        for (int w = 0; w < 4; w++) exp_q.push_back(vecs[0].exp_w[32*w +: 32]);
        consume(4, 1'b0, "arst_post", cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc128_stream_core.md
Name: hc128_stream_core

Overview:
- Complete HC-128 keystream generator with a parametrised output FIFO and a valid/ack handshake.
- Performs key/IV expansion, fills the P and Q tables, runs the 1024 mixing steps, then produces one 32-bit keystream word per cycle into the FIFO.
- Consumers are the stream-cipher datapath and the bus wrapper.

Parameters:
- FIFO_DEPTH, 4, keystream FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  single-cycle pulse; samples key/iv and starts initialisation.
- key  input  128  key; K[i] = key[32i+31:32i], i=0..3.
- iv  input  128  IV; IV[i] = iv[32i+31:32i], i=0..3.
- ready  output  1  high when initialisation is complete (RUN state).
- keystream_data  output  32  FIFO head word.
- keystream_valid  output  1  FIFO non-empty.
- keystream_ack  input  1  consumer accepts head word when keystream_valid=1.

Behaviour:
- Reset (async, reset=1):
  - State=IDLE; FIFO empty.
  - ready=0, keystream_valid=0, keystream_data=0.
  - Step counter is cleared. P/Q tables are not reset.
- Functions (rotr/rotl/shr on 32 bits, + mod 2^32):
  - f1 = rotr7^rotr18^shr3; f2 = rotr17^rotr19^shr10.
  - g1(x,y,z) = (rotr10 x ^ rotr23 z) + rotr8 y.
  - g2(x,y,z) = (rotl10 x ^ rotl23 z) + rotl8 y.
  - h1(x) = Q[x[7:0]] + Q[256+x[23:16]].
  - h2(x) = P[x[7:0]] + P[256+x[23:16]].
- Tables: P, Q are 512x32 register arrays with combinational reads. Exactly one step per cycle.
- State machine:
  - IDLE: waits for init.
  - LOAD (1 cycle): 16-word window = K0..K3, K0..K3, IV0..IV3, IV0..IV3 (W[0..15]).
  - EXPAND (1264 cycles, i=16..1279): W[i] = f2(W[i-2]) + W[i-7] + f1(W[i-15]) + W[i-16] + i. Window shifts. W[i] goes to P[i-256] for 256≤i≤767 and to Q[i-768] for 768≤i≤1279.
  - MIX (1024 cycles, i=0..1023): standard update step (below); the output is XORed into the table entry instead of being emitted.
  - RUN: ready=1; performs update steps.
- Update step, j = i mod 512, indices mod 512:
  - If i<512: P[j] += g1(P[j-3],P[j-10],P[j-511]); s = h1(P[j-12]) ^ P[j]_new.
  - Otherwise: same with Q, g2, h2.
  - MIX then writes table[j] = table[j]_new ^ h(table[j-12]).
  - i is a 10-bit counter, wraps 1023→0.
- Latency: ready rises exactly 2289 clock edges after the edge sampling init (1+1264+1024).
- RUN generation:
  - A step executes and s is pushed when the FIFO is not full, or is full with a simultaneous pop (ack&&valid).
  - Otherwise the step stalls: i and tables hold.
- FIFO behaviour:
  - Push and pop may occur in the same cycle; occupancy is unchanged.
  - Head word appears the cycle after its push (1-cycle latency from step to valid).
  - Full throughput is 1 word/cycle with ack held high.
  - keystream_ack with keystream_valid=0 is ignored.
  - keystream_data holds its value while valid=1 and ack=0. It is 0 when empty.
- init while not IDLE (any state, including mid-EXPAND/MIX/RUN):
  - Restarts at LOAD with the new key/iv.
  - FIFO is flushed and ready drops on the next edge.
  - A pending ack in that cycle is discarded.
- Reset mid-operation: immediate return to reset state. The next init gives full initialisation.

Test Plan:
- key=0, iv=0, init pulse -> ready rises 2289 cycles later; with ack=1 the words are 0x73150082, 0x3BFD03A0, 0xFB2FD77F, 0xAA63AF0E.
- Same init, ack=0 -> valid rises, FIFO fills to FIFO_DEPTH, generation stalls. Assert ack with random gaps for 64 words -> sequence is identical to an unstalled run, with no drops or duplicates.
- Random key/iv, ack=1, 2100 words -> bit-exact with the software model across the P→Q switch at 512 and the counter wrap at 1024 and 2048.
- init re-pulse at cycle 1500 (mid-MIX) with new key -> ready stays 0, ready rises 2289 cycles after the second init, and output matches the model for the new key only.
- Assert reset asynchronously while RUN with FIFO half full -> valid/ready/data go to 0 immediately. A subsequent init with key=0, iv=0 reproduces the vector above.
- Pulse ack during EXPAND/IDLE -> no state change, valid stays 0.
